// File: rtl/fetch_instruction.sv
// fetch_instruction: instruction fetch stage with PC, request/ready imem port,
// one-entry delivery buffer, redirect handling, HALT stop and sticky error flag.
`default_nettype none

module fetch_instruction #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned TIMEOUT   = 15,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        imem_rdy,
    input  logic [15:0] imem_rdata,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] instruction,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DELIVER = 2'd1,
        HALTED  = 2'd2
    } state_t;

    localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
    localparam logic [15:0] PC_STEP     = 16'd2;

    state_t      state, state_next;
    logic [15:0] pc, pc_next;
    logic        req, req_next;
    logic [15:0] instr_buf, instr_buf_next;
    logic [15:0] pc_plus2_q, pc_plus2_next;
    logic        valid, valid_next;
    logic        halted_q, halted_next;
    logic        err_q, err_next;
    logic [7:0]  wait_cnt, wait_cnt_next;
    logic [7:0]  wait_cnt_inc;

    assign wait_cnt_inc = wait_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            req        <= 1'b0;
            instr_buf  <= NOP_INSTR;
            pc_plus2_q <= RESET_PC + PC_STEP;
            valid      <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt   <= 8'd0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            req        <= req_next;
            instr_buf  <= instr_buf_next;
            pc_plus2_q <= pc_plus2_next;
            valid      <= valid_next;
            halted_q   <= halted_next;
            err_q      <= err_next;
            wait_cnt   <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        req_next       = req;
        instr_buf_next = instr_buf;
        pc_plus2_next  = pc_plus2_q;
        valid_next     = valid;
        halted_next    = halted_q;
        err_next       = err_q;
        wait_cnt_next  = wait_cnt;

        case (state)
            FETCH: begin
                if (redirect) begin
                    state_next    = FETCH;
                    pc_next       = {redirect_pc[15:1], 1'b0};
                    req_next      = 1'b1;
                    valid_next    = 1'b0;
                    wait_cnt_next = 8'd0;
                    if (redirect_pc[0]) err_next = 1'b1;
                end else if (req && imem_rdy) begin
                    // A response only counts against an outstanding request.
                    state_next     = DELIVER;
                    instr_buf_next = imem_rdata;
                    pc_plus2_next  = pc + PC_STEP;
                    valid_next     = 1'b1;
                    req_next       = 1'b0;
                    wait_cnt_next  = 8'd0;
                end else begin
                    req_next = 1'b1;
                    if (req) begin
                        if (wait_cnt < TIMEOUT_CNT) wait_cnt_next = wait_cnt_inc;
                        if (wait_cnt_inc == TIMEOUT_CNT) err_next = 1'b1;
                    end
                end
            end
            DELIVER: begin
                if (redirect) begin
                    state_next    = FETCH;
                    pc_next       = {redirect_pc[15:1], 1'b0};
                    req_next      = 1'b1;
                    valid_next    = 1'b0;
                    wait_cnt_next = 8'd0;
                    if (redirect_pc[0]) err_next = 1'b1;
                end else if (!stall) begin
                    valid_next = 1'b0;
                    if (instr_buf[15:11] == HALT_OPCODE) begin
                        state_next  = HALTED;
                        halted_next = 1'b1;
                        req_next    = 1'b0;
                    end else begin
                        state_next = FETCH;
                        pc_next    = pc + PC_STEP;
                        req_next   = 1'b1;
                    end
                end
            end
            HALTED: begin
                req_next   = 1'b0;
                valid_next = 1'b0;
            end
            default: begin
                state_next = FETCH;
                req_next   = 1'b0;
                valid_next = 1'b0;
            end
        endcase
    end

    assign imem_req    = req;
    assign imem_addr   = pc;
    assign instruction = valid ? instr_buf : NOP_INSTR;
    assign pc_plus2    = pc_plus2_q;
    assign instr_valid = valid;
    assign halted      = halted_q;
    assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_instruction.sv
// Testbench for fetch_instruction: bench-side memory responder with a scoreboard of delivered words.
`default_nettype none

module tb_fetch_instruction;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_rdy;
    logic [15:0] imem_rdata;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] instruction;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        halted;
    logic        err;

    int total;
    int bad;
    logic        prev_valid;
    logic [31:0] exp_q[$];

    fetch_instruction #(
        .RESET_PC (16'h0000),
        .TIMEOUT  (15),
        .NOP_INSTR(16'h0800)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_rdy   (imem_rdy),
        .imem_rdata (imem_rdata),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .instruction(instruction),
        .pc_plus2   (pc_plus2),
        .instr_valid(instr_valid),
        .halted     (halted),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and pop the scoreboard whenever a new word is presented.
    task automatic step();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", {16'h0, instruction}, {16'h0, e[31:16]});
                chk("sb_pc2", {16'h0, pc_plus2}, {16'h0, e[15:0]});
            end
        end
        prev_valid = instr_valid;
    endtask

    task automatic respond(input logic [15:0] data);
        imem_rdy   = 1'b1;
        imem_rdata = data;
        exp_q.push_back({data, imem_addr + 16'd2});
        step();
        imem_rdy   = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        prev_valid = 1'b0;
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0;
        imem_rdy = 1'b0;
        imem_rdata = 16'h0;
        #2 rst = 1'b0;
        step();
        step();
        chk("rst_req", {31'h0, imem_req}, 32'd0);
        chk("rst_addr", {16'h0, imem_addr}, 32'h0000);
        chk("rst_instr", {16'h0, instruction}, 32'h0800);
        chk("rst_pc2", {16'h0, pc_plus2}, 32'h0002);
        chk("rst_valid", {31'h0, instr_valid}, 32'd0);
        chk("rst_halted", {31'h0, halted}, 32'd0);
        chk("rst_err", {31'h0, err}, 32'd0);

        rst = 1'b1;
        step();
        chk("first_req", {31'h0, imem_req}, 32'd1);
        chk("first_addr", {16'h0, imem_addr}, 32'h0000);

        // First word, held under stall for three cycles
        stall = 1'b1;
        respond(16'h4020);
        chk("d0_valid", {31'h0, instr_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_instr", {16'h0, instruction}, 32'h4020);
            chk("stall_pc2", {16'h0, pc_plus2}, 32'h0002);
            chk("stall_noreq", {31'h0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        step();
        chk("next_req", {31'h0, imem_req}, 32'd1);
        chk("next_addr", {16'h0, imem_addr}, 32'h0002);
        chk("next_nop", {16'h0, instruction}, 32'h0800);

        // Response after two wait cycles
        step();
        step();
        chk("wait_addr", {16'h0, imem_addr}, 32'h0002);
        respond(16'h1234);
        step();
        chk("seq_addr", {16'h0, imem_addr}, 32'h0004);

        // Redirect wins over a simultaneous response
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        imem_rdy = 1'b1;
        imem_rdata = 16'h5555;
        step();
        redirect = 1'b0;
        imem_rdy = 1'b0;
        chk("redir_addr", {16'h0, imem_addr}, 32'h0100);
        chk("redir_valid", {31'h0, instr_valid}, 32'd0);
        chk("redir_err", {31'h0, err}, 32'd0);

        redirect = 1'b1;
        redirect_pc = 16'h0101;
        step();
        redirect = 1'b0;
        chk("odd_addr", {16'h0, imem_addr}, 32'h0100);
        chk("odd_err", {31'h0, err}, 32'd1);
        step();
        chk("err_sticky", {31'h0, err}, 32'd1);

        // Reset mid-request, late response across release
        rst = 1'b0;
        #1;
        chk("arst_err", {31'h0, err}, 32'd0);
        chk("arst_req", {31'h0, imem_req}, 32'd0);
        chk("arst_addr", {16'h0, imem_addr}, 32'h0000);
        step();
        imem_rdy = 1'b1;
        imem_rdata = 16'h7777;
        rst = 1'b1;
        step();
        imem_rdy = 1'b0;
        chk("late_valid", {31'h0, instr_valid}, 32'd0);
        chk("late_req", {31'h0, imem_req}, 32'd1);

        // Timeout: err on the 15th unanswered edge
        for (int i = 0; i < 14; i++) step();
        chk("to_before", {31'h0, err}, 32'd0);
        step();
        chk("to_hit", {31'h0, err}, 32'd1);
        step();
        chk("to_hold", {31'h0, err}, 32'd1);
        chk("to_req", {31'h0, imem_req}, 32'd1);

        // PC wrap from FFFE
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        chk("wrap_addr", {16'h0, imem_addr}, 32'hFFFE);
        respond(16'h4321);
        step();
        chk("wrap_next", {16'h0, imem_addr}, 32'h0000);

        // HALT fetch and terminal state
        respond(16'h0000);
        chk("halt_valid", {31'h0, instr_valid}, 32'd1);
        step();
        chk("halt_flag", {31'h0, halted}, 32'd1);
        chk("halt_req", {31'h0, imem_req}, 32'd0);
        chk("halt_nop", {16'h0, instruction}, 32'h0800);
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        imem_rdy = 1'b1;
        for (int i = 0; i < 3; i++) step();
        redirect = 1'b0;
        imem_rdy = 1'b0;
        chk("halt_ign_addr", {16'h0, imem_addr}, 32'h0000);
        chk("halt_ign_req", {31'h0, imem_req}, 32'd0);
        chk("halt_ign_valid", {31'h0, instr_valid}, 32'd0);
        chk("halt_ign_flag", {31'h0, halted}, 32'd1);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_instruction.md
Name: fetch_instruction

Overview:
- Instruction fetch stage; sits directly upstream of the decode stage and supplies its 16-bit instruction word.
- Holds the PC and drives a request/ready instruction-memory interface.
- Buffers one fetched instruction until decode accepts it.
- Applies branch/jump redirects and stops fetching after a HALT instruction.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
TIMEOUT, 15, max cycles imem_req may stay unanswered before err is raised (1..255)
NOP_INSTR, 16'h0800, word driven on instruction when no valid instruction is held

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
stall  input  1  decode not ready; buffered instruction must be held
redirect  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  16  redirect target
imem_rdy  input  1  memory returns imem_rdata this cycle
imem_rdata  input  16  instruction word from memory
imem_req  output  1  fetch request, registered
imem_addr  output  16  fetch address (= pc)
instruction  output  16  instruction to decode
pc_plus2  output  16  pc+2 of the instruction presented
instr_valid  output  1  instruction/pc_plus2 valid
halted  output  1  HALT was accepted; fetch stopped
err  output  1  sticky error flag

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, state=FETCH, imem_req=0, instruction=NOP_INSTR, pc_plus2=RESET_PC+2, instr_valid=0, halted=0, err=0, wait counter=0.
- First imem_req=1 occurs on the first rising edge after rst deasserts.
- States: FETCH, DELIVER, HALTED.
- FETCH:
  - imem_req=1, imem_addr=pc; wait counter increments each cycle without imem_rdy.
  - On imem_rdy (no redirect): latch imem_rdata into instruction, pc_plus2=pc+2, instr_valid=1, imem_req=0, counter=0, go to DELIVER. Minimum latency is 1 cycle from request to instr_valid.
- DELIVER:
  - instruction and pc_plus2 are held stable while stall=1.
  - If stall=0 and instruction[15:11]=5'b00000 (HALT): instr_valid=0, halted=1, go to HALTED.
  - Else if stall=0: pc=pc+2, instr_valid=0, go to FETCH.
- HALTED:
  - Terminal state until reset. imem_req=0, instr_valid=0, instruction=NOP_INSTR.
  - redirect and imem_rdy are ignored.
- Redirect (FETCH or DELIVER):
  - Highest priority; overrides imem_rdy and stall in the same cycle.
  - pc={redirect_pc[15:1],1'b0}; discard any buffered or returning word; instr_valid=0; counter=0; go to FETCH.
  - If redirect_pc[0]=1, also set err.
- Timeout: if the counter reaches TIMEOUT while in FETCH, set err. Fetch continues waiting.
- err is sticky: cleared only by reset.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000, no error.
- Reset asserted mid-request: all state returns to reset values immediately; a late imem_rdy after reset release is ignored unless imem_req=1.

Test Plan:
- Reset release, memory returns 16'h4020 at address 0 after 1 cycle -> imem_addr=0000, instr_valid=1, instruction=4020, pc_plus2=0002; next fetch at 0002.
- Instruction held with stall=1 for 3 cycles -> instruction/pc_plus2 unchanged and no imem_req; stall=0 -> next request at pc+2.
- Redirect to 16'h0100 in the same cycle as imem_rdy -> returned word dropped, imem_addr=0100 next cycle, instr_valid=0.
- redirect_pc=16'h0101 -> fetch at 0100, err=1 and stays 1.
- Fetch of 16'h0000 (HALT), stall=0 -> halted=1, imem_req=0, instruction=0800; later redirect ignored.
- imem_rdy withheld for 16 cycles -> err=1 at the cycle the counter hits 15; pc=FFFE fetch followed by 0000.
